axis_alex_seq: RTL and testbench

AXIS_ALEX_SEQ -- requirements
Module: axis_alex_seq

---
 rtl/axis_alex_seq.sv | 147 ++++++++++++++
 tb/tb_axis_alex_seq.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_alex_seq.sv
// axis_alex_seq: two-port AXI-Stream sequencer feeding a serializer.
// Each slave port has a one-entry holding register. An IDLE/ISSUE/WAIT FSM
// round-robins between the ports and issues one word per handshake. Each
// handshake is followed by a guard interval of WAIT_CYCLES clock cycles.
module axis_alex_seq #(
    parameter int WAIT_CYCLES = 2200
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic [15:0] s_axis_rx_tdata,
    input  logic        s_axis_rx_tvalid,
    output logic        s_axis_rx_tready,
    input  logic [15:0] s_axis_tx_tdata,
    input  logic        s_axis_tx_tvalid,
    output logic        s_axis_tx_tready,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        busy,
    output logic        last_grant,
    output logic [15:0] issued_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    // The counter is loaded with WAIT_CYCLES-1 and runs down through 0,
    // which gives exactly WAIT_CYCLES cycles in WAIT.
    localparam logic [11:0] WAIT_LOAD = 12'(WAIT_CYCLES - 1);

    state_t      state_q, state_d;
    logic        rx_pend_q, rx_pend_d;
    logic [15:0] rx_data_q, rx_data_d;
    logic        tx_pend_q, tx_pend_d;
    logic [15:0] tx_data_q, tx_data_d;
    logic [31:0] m_tdata_q, m_tdata_d;
    logic        m_tvalid_q, m_tvalid_d;
    logic        last_grant_q, last_grant_d;
    logic [15:0] issued_cnt_q, issued_cnt_d;
    logic [11:0] wait_cnt_q, wait_cnt_d;
    logic        grant_tx;

    // A port is ready exactly when its holding register is empty.
    assign s_axis_rx_tready = ~rx_pend_q;
    assign s_axis_tx_tready = ~tx_pend_q;
    assign m_axis_tdata     = m_tdata_q;
    assign m_axis_tvalid    = m_tvalid_q;
    assign busy             = (state_q != ST_IDLE);
    assign last_grant       = last_grant_q;
    assign issued_cnt       = issued_cnt_q;

    // Next-state logic: port capture, arbitration, issue and guard timing.
    always_comb begin
        state_d      = state_q;
        rx_pend_d    = rx_pend_q;
        rx_data_d    = rx_data_q;
        tx_pend_d    = tx_pend_q;
        tx_data_d    = tx_data_q;
        m_tdata_d    = m_tdata_q;
        m_tvalid_d   = m_tvalid_q;
        last_grant_d = last_grant_q;
        issued_cnt_d = issued_cnt_q;
        wait_cnt_d   = wait_cnt_q;
        // TX wins only when it is alone, or on a tie after RX was served last.
        grant_tx     = tx_pend_q && (!rx_pend_q || !last_grant_q);

        // Ports capture whenever empty, independent of the FSM state.
        if (s_axis_rx_tvalid && !rx_pend_q) begin
            rx_pend_d = 1'b1;
            rx_data_d = s_axis_rx_tdata;
        end
        if (s_axis_tx_tvalid && !tx_pend_q) begin
            tx_pend_d = 1'b1;
            tx_data_d = s_axis_tx_tdata;
        end

        case (state_q)
            ST_IDLE: begin
                if (rx_pend_q || tx_pend_q) begin
                    m_tdata_d    = grant_tx ? {14'd0, 2'b10, tx_data_q}
                                            : {14'd0, 2'b01, rx_data_q};
                    m_tvalid_d   = 1'b1;
                    last_grant_d = grant_tx;
                    state_d      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // last_grant_q identifies the port being served. The pending
                // flag being cleared here is still set this cycle, so that
                // port cannot also capture a new word on this edge.
                if (m_axis_tready) begin
                    m_tvalid_d   = 1'b0;
                    if (last_grant_q) begin
                        tx_pend_d = 1'b0;
                    end else begin
                        rx_pend_d = 1'b0;
                    end
                    issued_cnt_d = issued_cnt_q + 16'd1;
                    wait_cnt_d   = WAIT_LOAD;
                    state_d      = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_q == 12'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q - 12'd1;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                m_tvalid_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any transfer and drops held words.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q      <= ST_IDLE;
            rx_pend_q    <= 1'b0;
            rx_data_q    <= 16'd0;
            tx_pend_q    <= 1'b0;
            tx_data_q    <= 16'd0;
            m_tdata_q    <= 32'd0;
            m_tvalid_q   <= 1'b0;
            last_grant_q <= 1'b1;
            issued_cnt_q <= 16'd0;
            wait_cnt_q   <= 12'd0;
        end else begin
            state_q      <= state_d;
            rx_pend_q    <= rx_pend_d;
            rx_data_q    <= rx_data_d;
            tx_pend_q    <= tx_pend_d;
            tx_data_q    <= tx_data_d;
            m_tdata_q    <= m_tdata_d;
            m_tvalid_q   <= m_tvalid_d;
            last_grant_q <= last_grant_d;
            issued_cnt_q <= issued_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
        end
    end

endmodule

// File: tb/tb_axis_alex_seq.sv
// tb_axis_alex_seq: scoreboard bench for axis_alex_seq.
// Stimulus is driven 1 time unit after the rising edge. All observation
// happens on the falling edge.
module tb_axis_alex_seq;

    localparam int W      = 6;
    localparam int BUDGET = 500;

    logic        clk = 1'b0;
    logic        areset;
    logic [15:0] s_axis_rx_tdata;
    logic        s_axis_rx_tvalid;
    logic        s_axis_rx_tready;
    logic [15:0] s_axis_tx_tdata;
    logic        s_axis_tx_tvalid;
    logic        s_axis_tx_tready;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        busy;
    logic        last_grant;
    logic [15:0] issued_cnt;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    logic [31:0] sb[$];
    logic [31:0] exp_word;
    logic [15:0] exp_cnt;

    // Monitor state
    logic        tvalid_prev = 1'b0;
    logic        hs_prev = 1'b0;
    logic [31:0] hs_data = 32'd0;
    logic        rise_seen = 1'b0;
    int          rise_cyc = 0;
    int          busy_run = 0;
    int          busy_len = 0;

    axis_alex_seq #(.WAIT_CYCLES(W)) dut (
        .aclk             (clk),
        .areset           (areset),
        .s_axis_rx_tdata  (s_axis_rx_tdata),
        .s_axis_rx_tvalid (s_axis_rx_tvalid),
        .s_axis_rx_tready (s_axis_rx_tready),
        .s_axis_tx_tdata  (s_axis_tx_tdata),
        .s_axis_tx_tvalid (s_axis_tx_tvalid),
        .s_axis_tx_tready (s_axis_tx_tready),
        .m_axis_tdata     (m_axis_tdata),
        .m_axis_tvalid    (m_axis_tvalid),
        .m_axis_tready    (m_axis_tready),
        .busy             (busy),
        .last_grant       (last_grant),
        .issued_cnt       (issued_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Monitor: scoreboard compare on each handshake, post-handshake hold,
    // tvalid rise spacing and busy run length.
    always @(negedge clk) begin
        if (areset) begin
            rise_seen = 1'b0;
            hs_prev   = 1'b0;
        end else begin
            if (hs_prev) begin
                check("post_hs_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
                check("post_hs_hold", m_axis_tdata, hs_data);
            end
            hs_prev = 1'b0;
            if (m_axis_tvalid && !tvalid_prev) begin
                if (rise_seen)
                    check("rise_spacing_ok", {31'd0, (cyc - rise_cyc) >= (W + 2)}, 32'd1);
                rise_cyc  = cyc;
                rise_seen = 1'b1;
            end
            if (m_axis_tvalid && m_axis_tready) begin
                check("sb_depth", (sb.size() > 0) ? 32'd1 : 32'd0, 32'd1);
                if (sb.size() > 0) begin
                    exp_word = sb.pop_front();
                    check("hs_tdata", m_axis_tdata, exp_word);
                    $display("handshake tdata=0x%08h expected=0x%08h issued_cnt=%0d",
                             m_axis_tdata, exp_word, issued_cnt);
                end
                hs_prev = 1'b1;
                hs_data = m_axis_tdata;
            end
        end
        tvalid_prev = m_axis_tvalid;
        if (busy) begin
            busy_run++;
        end else if (busy_run > 0) begin
            busy_len = busy_run;
            busy_run = 0;
        end
    end

    task automatic do_reset();
        areset = 1'b1;
        @(posedge clk); #1;
        areset = 1'b0;
    endtask

    task automatic rx_send(input logic [15:0] d);
        int n;
        n = 0;
        s_axis_rx_tdata  = d;
        s_axis_rx_tvalid = 1'b1;
        forever begin
            @(negedge clk);
            if (s_axis_rx_tready) break;
            n++;
            if (n >= BUDGET) begin
                check("rx_accept_timeout", {31'd0, s_axis_rx_tready}, 32'd1);
                break;
            end
        end
        @(posedge clk); #1;
        s_axis_rx_tvalid = 1'b0;
    endtask

    task automatic tx_send(input logic [15:0] d);
        int n;
        n = 0;
        s_axis_tx_tdata  = d;
        s_axis_tx_tvalid = 1'b1;
        forever begin
            @(negedge clk);
            if (s_axis_tx_tready) break;
            n++;
            if (n >= BUDGET) begin
                check("tx_accept_timeout", {31'd0, s_axis_tx_tready}, 32'd1);
                break;
            end
        end
        @(posedge clk); #1;
        s_axis_tx_tvalid = 1'b0;
    endtask

    // Returns on the falling edge where tvalid is first seen high.
    task automatic wait_tvalid();
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (m_axis_tvalid) break;
            n++;
            if (n >= BUDGET) begin
                check("tvalid_timeout", {31'd0, m_axis_tvalid}, 32'd1);
                break;
            end
        end
    endtask

    task automatic wait_issued(input logic [15:0] target);
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (issued_cnt == target) break;
            n++;
            if (n >= BUDGET) begin
                check("issued_timeout", {16'd0, issued_cnt}, {16'd0, target});
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (!busy) break;
            n++;
            if (n >= BUDGET) begin
                check("idle_timeout", {31'd0, busy}, 32'd0);
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        areset           = 1'b1;
        s_axis_rx_tdata  = 16'd0;
        s_axis_rx_tvalid = 1'b0;
        s_axis_tx_tdata  = 16'd0;
        s_axis_tx_tvalid = 1'b0;
        m_axis_tready    = 1'b0;
        exp_cnt          = 16'd0;
        repeat (3) @(posedge clk);
        #1 areset = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
        check("rst_tdata", m_axis_tdata, 32'd0);
        check("rst_rx_tready", {31'd0, s_axis_rx_tready}, 32'd1);
        check("rst_tx_tready", {31'd0, s_axis_tx_tready}, 32'd1);
        check("rst_issued", {16'd0, issued_cnt}, 32'd0);
        check("rst_last_grant", {31'd0, last_grant}, 32'd1);
        @(posedge clk); #1;

        // Single RX word, tready pulsed one cycle after tvalid
        sb.push_back(32'h0001A5C3);
        rx_send(16'hA5C3);
        wait_tvalid();
        @(posedge clk); #1 m_axis_tready = 1'b1;
        @(posedge clk); #1 m_axis_tready = 1'b0;
        exp_cnt = exp_cnt + 16'd1;
        wait_idle();
        check("single_busy_len", busy_len, W + 2);
        check("single_issued", {16'd0, issued_cnt}, {16'd0, exp_cnt});
        check("single_rx_tready", {31'd0, s_axis_rx_tready}, 32'd1);

        // Simultaneous RX/TX capture after reset: RX wins the first tie
        do_reset();
        exp_cnt = 16'd0;
        m_axis_tready    = 1'b1;
        sb.push_back(32'h00011111);
        sb.push_back(32'h00022222);
        s_axis_rx_tdata  = 16'h1111;
        s_axis_tx_tdata  = 16'h2222;
        s_axis_rx_tvalid = 1'b1;
        s_axis_tx_tvalid = 1'b1;
        @(posedge clk); #1;
        s_axis_rx_tvalid = 1'b0;
        s_axis_tx_tvalid = 1'b0;
        exp_cnt = exp_cnt + 16'd2;
        wait_issued(exp_cnt);
        wait_idle();
        check("tie_last_grant", {31'd0, last_grant}, 32'd1);
        check("tie_sb_empty", sb.size(), 32'd0);
        m_axis_tready = 1'b0;

        // Back-pressure: tready held low for 50 cycles in ISSUE
        sb.push_back(32'h00013C3C);
        rx_send(16'h3C3C);
        wait_tvalid();
        for (int i = 0; i < 50; i++) begin
            check("stall_tvalid", {31'd0, m_axis_tvalid}, 32'd1);
            check("stall_tdata", m_axis_tdata, 32'h00013C3C);
            check("stall_issued", {16'd0, issued_cnt}, {16'd0, exp_cnt});
            @(negedge clk);
        end
        @(posedge clk); #1 m_axis_tready = 1'b1;
        @(posedge clk); #1 m_axis_tready = 1'b0;
        exp_cnt = exp_cnt + 16'd1;
        wait_idle();
        check("stall_busy_len", busy_len, W + 52);
        check("stall_issued_after", {16'd0, issued_cnt}, {16'd0, exp_cnt});

        // TX word offered during WAIT while a TX word is already pending
        m_axis_tready = 1'b1;
        sb.push_back(32'h00015555);
        rx_send(16'h5555);
        sb.push_back(32'h00021234);
        tx_send(16'h1234);
        wait_issued(exp_cnt + 16'd1);
        sb.push_back(32'h0002BEEF);
        s_axis_tx_tdata  = 16'hBEEF;
        s_axis_tx_tvalid = 1'b1;
        @(negedge clk);
        check("wait_tx_tready_low", {31'd0, s_axis_tx_tready}, 32'd0);
        @(posedge clk); #1;
        tx_send(16'hBEEF);
        check("beef_after_1234", {16'd0, issued_cnt}, {16'd0, exp_cnt + 16'd2});
        exp_cnt = exp_cnt + 16'd3;
        wait_issued(exp_cnt);
        wait_idle();
        check("beef_sb_empty", sb.size(), 32'd0);

        // Reset pulsed mid-WAIT with an RX word pending
        sb.push_back(32'h00017777);
        rx_send(16'h7777);
        rx_send(16'h8888);
        @(posedge clk); #1;
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        areset = 1'b1;
        @(posedge clk); #1;
        areset = 1'b0;
        exp_cnt = 16'd0;
        @(negedge clk);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
        check("midrst_rx_tready", {31'd0, s_axis_rx_tready}, 32'd1);
        check("midrst_tx_tready", {31'd0, s_axis_tx_tready}, 32'd1);
        check("midrst_issued", {16'd0, issued_cnt}, 32'd0);
        check("midrst_tdata", m_axis_tdata, 32'd0);
        repeat (10) @(negedge clk);
        check("midrst_discard_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
        check("midrst_sb_empty", sb.size(), 32'd0);
        @(posedge clk); #1;
        m_axis_tready = 1'b0;

        // Counter wrap: preload near 0xFFFF, then two handshakes
        force dut.issued_cnt_q = 16'hFFFE;
        @(negedge clk);
        release dut.issued_cnt_q;
        @(posedge clk); #1;
        check("preload_issued", {16'd0, issued_cnt}, 32'h0000FFFE);
        m_axis_tready = 1'b1;
        sb.push_back(32'h0001000A);
        rx_send(16'h000A);
        wait_issued(16'hFFFF);
        sb.push_back(32'h0002000B);
        tx_send(16'h000B);
        wait_issued(16'h0000);
        wait_idle();
        check("wrap_issued", {16'd0, issued_cnt}, 32'd0);
        check("wrap_last_grant", {31'd0, last_grant}, 32'd1);
        m_axis_tready = 1'b0;

        check("final_sb_empty", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
